// File: rtl/acc_avg_buffer.sv
// rtl/acc_avg_buffer.sv - rounded, saturated average of accumulated sums, buffered in a small FIFO
module acc_avg_buffer #(
  parameter int IN_W  = 12,
  parameter int OUT_W = 8,
  parameter int SHIFT = 4,
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_valid,
  input  logic signed [IN_W-1:0]     i_acc,
  input  logic                       i_ready,
  input  logic                       i_clr_ovf,
  output logic signed [OUT_W-1:0]    o_data,
  output logic                       o_valid,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = IN_W + 1;
  localparam logic [CW-1:0]        FULL_CNT = CW'(DEPTH);
  localparam logic signed [EW-1:0] RND      = EW'(2 ** (SHIFT - 1));
  localparam logic signed [EW-1:0] MAX_V    = EW'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [EW-1:0] MIN_V    = EW'(-(2 ** (OUT_W - 1)));

  logic signed [OUT_W-1:0] mem [DEPTH];
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [CW-1:0]           count_q, count_d;
  logic                    valid_q;
  logic                    ovf_q;

  logic signed [EW-1:0]    ext, rnd, shr;
  logic signed [OUT_W-1:0] conv;
  logic                    full, push, pop, drop;

  // One guard bit keeps max-positive + rounding constant from wrapping negative.
  always_comb begin
    ext = {i_acc[IN_W-1], i_acc};
    rnd = ext + RND;
    shr = rnd >>> SHIFT;
    if (shr > MAX_V)
      conv = MAX_V[OUT_W-1:0];
    else if (shr < MIN_V)
      conv = MIN_V[OUT_W-1:0];
    else
      conv = shr[OUT_W-1:0];
  end

  always_comb begin
    full = (count_q == FULL_CNT);
    pop  = valid_q && i_ready;
    push = i_valid && (!full || pop);
    drop = i_valid && full && !pop;
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (push)
      mem[wr_ptr] <= conv;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      count_q <= count_d;
      valid_q <= (count_d != '0);
      // A drop on the same edge as a clear leaves the flag set.
      if (drop)
        ovf_q <= 1'b1;
      else if (i_clr_ovf)
        ovf_q <= 1'b0;
    end
  end

  // Gating by valid forces o_data to 0 during reset, when storage is undefined.
  assign o_data     = valid_q ? mem[rd_ptr] : '0;
  assign o_valid    = valid_q;
  assign o_count    = count_q;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_acc_avg_buffer.sv
// tb/tb_acc_avg_buffer.sv - directed self-checking bench for acc_avg_buffer
module tb_acc_avg_buffer;

  logic              clk;
  logic              rst_n;
  logic              valid;
  logic signed [11:0] acc;
  logic              ready;
  logic              clr_ovf;
  logic signed [7:0] data;
  logic              dvalid;
  logic [2:0]        count;
  logic              ovf;

  int errors = 0;
  int checks = 0;

  acc_avg_buffer #(.IN_W(12), .OUT_W(8), .SHIFT(4), .DEPTH(4)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_valid    (valid),
    .i_acc      (acc),
    .i_ready    (ready),
    .i_clr_ovf  (clr_ovf),
    .o_data     (data),
    .o_valid    (dvalid),
    .o_count    (count),
    .o_overflow (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int rnd_acc [5];
    int rnd_exp [5];
    rnd_acc = '{24, -24, -2048, 2047, -8};
    rnd_exp = '{2, -1, -128, 127, 0};

    rst_n = 1'b0; valid = 1'b0; acc = '0; ready = 1'b0; clr_ovf = 1'b0;
    tick(); tick();
    chk("rst_valid", dvalid, 0);
    chk("rst_count", count, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_data", data, 0);
    rst_n = 1'b1;
    tick();

    // single push, hold, then pop
    valid = 1'b1; acc = 12'sd160;
    tick();
    valid = 1'b0;
    chk("single_valid", dvalid, 1);
    chk("single_data", data, 10);
    chk("single_count", count, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_data", data, 10);
      chk("hold_valid", dvalid, 1);
    end
    ready = 1'b1;
    tick();
    chk("pop_valid", dvalid, 0);
    chk("pop_count", count, 0);

    // rounding and saturation
    for (int i = 0; i < 5; i++) begin
      valid = 1'b1; acc = 12'(rnd_acc[i]);
      tick();
      valid = 1'b0;
      chk("round_data", data, rnd_exp[i]);
      chk("round_count", count, 1);
      tick();
    end
    chk("round_empty", dvalid, 0);

    // fill, overflow, drain
    ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      valid = 1'b1; acc = 12'(16 * i);
      tick();
    end
    chk("fill_count", count, 4);
    chk("fill_ovf", ovf, 0);
    acc = 12'sd80;
    tick();
    valid = 1'b0;
    chk("drop_ovf", ovf, 1);
    chk("drop_count", count, 4);
    ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_data", data, i);
      tick();
    end
    chk("drain_empty", dvalid, 0);
    chk("drain_count", count, 0);
    ready = 1'b0;

    // overflow clear without drop
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("clr_ovf", ovf, 0);

    // refill, drop, then drop coinciding with clear
    for (int i = 1; i <= 4; i++) begin
      valid = 1'b1; acc = 12'(16 * i);
      tick();
    end
    acc = 12'sd80;
    tick();
    chk("drop2_ovf", ovf, 1);
    clr_ovf = 1'b1;
    tick();
    valid = 1'b0;
    chk("set_wins_ovf", ovf, 1);
    chk("set_wins_count", count, 4);
    tick();
    clr_ovf = 1'b0;
    chk("clr2_ovf", ovf, 0);

    // full with simultaneous push and pop
    valid = 1'b1; acc = 12'sd80; ready = 1'b1;
    tick();
    valid = 1'b0; ready = 1'b0;
    chk("pp_ovf", ovf, 0);
    chk("pp_count", count, 4);
    ready = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      chk("pp_drain", data, i);
      tick();
    end
    chk("pp_empty", dvalid, 0);
    ready = 1'b0;

    // async reset mid-stream
    for (int i = 1; i <= 3; i++) begin
      valid = 1'b1; acc = 12'(16 * i);
      tick();
    end
    valid = 1'b0;
    chk("pre_rst_count", count, 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", dvalid, 0);
    chk("arst_count", count, 0);
    chk("arst_ovf", ovf, 0);
    chk("arst_data", data, 0);
    tick();
    rst_n = 1'b1;
    tick();
    valid = 1'b1; acc = 12'sd160;
    tick();
    valid = 1'b0;
    chk("post_rst_data", data, 10);
    chk("post_rst_count", count, 1);
    chk("post_rst_valid", dvalid, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/acc_avg_buffer.md
Name: acc_avg_buffer

Overview:
- Downstream stage of the 16-sample accumulator.
- Captures each accumulated sum on its valid pulse and converts it to a rounded, saturated average (sum / 2^SHIFT).
- Stores averages in a small FIFO and presents them to the consumer over a valid/ready handshake.
- Reports fill level and a sticky overflow flag when results are dropped.

Parameters:
- IN_W, 12, width of signed input sum.
- OUT_W, 8, width of signed output average.
- SHIFT, 4, right-shift amount (log2 of samples per sum).
- DEPTH, 4, FIFO entries (power of two, >= 2).

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  single-cycle strobe: i_acc holds a completed sum.
- i_acc  input  IN_W  signed accumulated sum.
- i_ready  input  1  consumer accepts o_data this cycle.
- i_clr_ovf  input  1  synchronous clear of o_overflow.
- o_data  output  OUT_W  signed average at FIFO head.
- o_valid  output  1  FIFO non-empty; o_data is meaningful.
- o_count  output  log2(DEPTH)+1  entries currently held.
- o_overflow  output  1  sticky: a sum was dropped because the FIFO was full.

Behaviour:
- Reset (async, i_rst_n low): pointers, o_count, o_valid, o_overflow and o_data all go to 0 immediately. FIFO contents are don't-care. Any in-flight handshake is abandoned.

Conversion (combinational on the write path):
- Sign-extend i_acc to IN_W+1 bits.
- Add 2^(SHIFT-1), giving round-half-up toward +inf.
- Arithmetic shift right by SHIFT.
- Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- The extra bit prevents wrap when adding the rounding constant to the max positive input.

Push and pop:
- Push: on a rising edge with i_valid=1, if not full or a pop occurs the same edge, write the converted value at wr_ptr and advance it.
- Pop: on a rising edge with o_valid=1 and i_ready=1, advance rd_ptr.
- i_ready while empty is ignored.
- Pointers wrap modulo DEPTH.
- o_count: +1 on push only, -1 on pop only, unchanged on push+pop or neither.
- Simultaneous push and pop when full: both succeed, count stays DEPTH, no overflow.
- Simultaneous push and pop when empty: pop is invalid, push succeeds, count becomes 1.

Overflow:
- i_valid=1 while full with no same-edge pop: the sum is discarded, contents are unchanged, and o_overflow is set to 1 on that edge.
- i_clr_ovf clears o_overflow on the next edge.
- If a drop and i_clr_ovf occur on the same edge, set wins.

Outputs:
- o_valid = (o_count != 0), registered.
- o_data is the head entry, driven from registered storage and stable while o_valid=1 and i_ready=0.

Latency:
- A sum strobed at edge N into an empty FIFO is visible on o_data with o_valid=1 after edge N. No same-cycle bypass.

Reset mid-operation: the FIFO is empty after reset deassertion and the first post-reset push behaves as into an empty FIFO.

Test Plan:
- Reset then single push i_acc=160, i_ready=0 -> after next edge o_valid=1, o_data=10, o_count=1; hold 3 cycles, data stable; assert i_ready -> o_valid=0, o_count=0.
- Rounding and saturation, i_ready=1 throughout -> output sequence:
  - i_acc=24 -> 2 (1.5 rounds up).
  - i_acc=-24 -> -1 (-1.5 rounds toward +inf).
  - i_acc=-2048 -> -128.
  - i_acc=2047 -> 127 (saturated, no wrap).
  - i_acc=-8 -> 0.
- Fill with i_ready=0: push 16, 32, 48, 64 -> o_count=4; push 80 -> dropped, o_overflow=1, o_count=4; drain -> 1, 2, 3, 4 in order, then o_valid=0.
- Full with simultaneous push and pop: FIFO holds 1..4 (sums 16..64), i_valid=1 (i_acc=80) and i_ready=1 same edge -> o_overflow stays 0, o_count=4, drain yields 2, 3, 4, 5.
- Overflow clear: o_overflow=1, pulse i_clr_ovf with no drop -> 0 next edge; repeat with a drop on the same edge -> stays 1.
- Async reset mid-stream: with o_count=3, pull i_rst_n low between edges -> o_valid, o_count, o_overflow go to 0 immediately; after release, push 160 -> o_data=10, o_count=1.
